// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART TX core.
// A grant covers a whole packet; bytes are paced off u_tx_data_ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT     = 64,
  parameter int GAP_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           u_tx_data,
  output logic                 u_tx_data_valid,
  input  logic                 u_tx_data_ready,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic                 trunc,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, ARB, LOAD, ISSUE, DRAIN
  } state_t;

  state_t state, state_d;

  logic [2:0]  last_grant, last_grant_d;
  logic [2:0]  grant_id_d, pick;
  logic        found;
  logic [7:0]  byte_cnt, byte_cnt_d;
  logic [15:0] gap_cnt, gap_cnt_d;
  logic        end_q, end_d;
  logic        cut_q, cut_d;
  logic        seen_q, seen_d;
  logic        gv_d, valid_d, trunc_d, busy_d;
  logic [7:0]  data_d;
  logic [NUM_REQ-1:0] ack_d;

  logic [7:0]  vld8, last8, ack8;
  logic [63:0] data64;
  logic [7:0]  sel_data;
  logic        sel_vld, sel_last, at_max;
  logic [3:0]  idx;

  // Pad request buses to 8 lanes so a 3-bit owner index selects cleanly.
  always_comb begin
    vld8     = 8'(req_valid);
    last8    = 8'(req_last);
    data64   = 64'(req_data);
    sel_vld  = vld8[grant_id];
    sel_last = last8[grant_id];
    sel_data = data64[{grant_id, 3'b000} +: 8];
    ack8     = 8'd1 << grant_id;
    at_max   = byte_cnt == 8'(MAX_PKT - 1);
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant} + 4'(k);
      if (idx >= 4'(NUM_REQ))
        idx = idx - 4'(NUM_REQ);
      if (!found && vld8[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_id_d   = grant_id;
    byte_cnt_d   = byte_cnt;
    gap_cnt_d    = gap_cnt;
    end_d        = end_q;
    cut_d        = cut_q;
    seen_d       = seen_q;
    gv_d         = grant_valid;
    valid_d      = u_tx_data_valid;
    data_d       = u_tx_data;
    ack_d        = req_ack;
    trunc_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid)
          state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_id_d   = pick;
          last_grant_d = pick;
          gv_d         = 1'b1;
          byte_cnt_d   = '0;
          gap_cnt_d    = '0;
          state_d      = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (sel_vld) begin
          if (u_tx_data_ready) begin
            data_d     = sel_data;
            valid_d    = 1'b1;
            ack_d      = ack8[NUM_REQ-1:0];
            end_d      = sel_last | at_max;
            cut_d      = at_max & ~sel_last;
            byte_cnt_d = byte_cnt + 8'd1;
            gap_cnt_d  = '0;
            state_d    = ISSUE;
          end
        end else if (gap_cnt == 16'(GAP_TIMEOUT - 1)) begin
          gv_d    = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 16'd1;
        end
      end
      ISSUE: begin
        valid_d = 1'b0;
        ack_d   = '0;
        seen_d  = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: begin
        // The core must drop ready before its rise marks the byte done.
        if (!u_tx_data_ready) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          if (end_q) begin
            gv_d    = 1'b0;
            trunc_d = cut_q;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 3'(NUM_REQ - 1);
      grant_id        <= '0;
      byte_cnt        <= '0;
      gap_cnt         <= '0;
      end_q           <= 1'b0;
      cut_q           <= 1'b0;
      seen_q          <= 1'b0;
      grant_valid     <= 1'b0;
      u_tx_data_valid <= 1'b0;
      u_tx_data       <= '0;
      req_ack         <= '0;
      trunc           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      last_grant      <= last_grant_d;
      grant_id        <= grant_id_d;
      byte_cnt        <= byte_cnt_d;
      gap_cnt         <= gap_cnt_d;
      end_q           <= end_d;
      cut_q           <= cut_d;
      seen_q          <= seen_d;
      grant_valid     <= gv_d;
      u_tx_data_valid <= valid_d;
      u_tx_data       <= data_d;
      req_ack         <= ack_d;
      trunc           <= trunc_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART core model,
// requester FIFOs and an expected-byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MP   = 4;
  localparam int GT   = 10;
  localparam int BUSY = 4;

  logic clk, rst_n;
  logic [NR-1:0]   req_valid, req_last, req_ack;
  logic [NR*8-1:0] req_data;
  logic [7:0]      u_tx_data;
  logic            u_tx_data_valid, u_tx_data_ready;
  logic            grant_valid, trunc, busy;
  logic [2:0]      grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int trunc_cnt = 0;
  int rise_cyc = 0;
  int bcnt = 0;
  bit bp = 0;

  logic [8:0]  rmem [NR][64];
  int          rhead [NR];
  int          rtail [NR];
  logic [10:0] exp_q [$];

  uart_tx_arbiter #(
    .NUM_REQ(NR), .MAX_PKT(MP), .GAP_TIMEOUT(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack),
    .u_tx_data(u_tx_data),
    .u_tx_data_valid(u_tx_data_valid),
    .u_tx_data_ready(u_tx_data_ready),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .trunc(trunc), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(int r, logic [7:0] d, logic l);
    rmem[r][rtail[r] % 64] = {l, d};
    rtail[r]++;
  endtask

  task automatic expect_b(int r, logic [7:0] d);
    exp_q.push_back({3'(r), d});
  endtask

  function automatic int pend();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rtail[i] - rhead[i];
    return s;
  endfunction

  task automatic wait_issues(int target, string tag);
    int n = 0;
    while (issue_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 2000), 1);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !grant_valid && !busy
             && pend() == 0) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 3000), 1);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_ack"}, 32'(req_ack), 0);
    check({tag, "_data"}, 32'(u_tx_data), 0);
    check({tag, "_valid"}, 32'(u_tx_data_valid), 0);
    check({tag, "_gv"}, 32'(grant_valid), 0);
    check({tag, "_gid"}, 32'(grant_id), 0);
    check({tag, "_trunc"}, 32'(trunc), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Core model, requester FIFOs and output monitor.
  initial begin
    logic [10:0] e;
    logic [8:0]  w;
    for (int i = 0; i < NR; i++) rhead[i] = 0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    u_tx_data_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        for (int i = 0; i < NR; i++) rhead[i] = rtail[i];
        exp_q.delete();
      end else begin
        if (u_tx_data_valid) begin
          check("ready_at_issue", 32'(u_tx_data_ready), 1);
          check("issue_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_data", 32'(u_tx_data), 32'(e[7:0]));
            check("issue_gid", 32'(grant_id), 32'(e[10:8]));
            check("issue_ack", 32'(req_ack),
                  32'(1) << e[10:8]);
          end
          issue_cnt++;
          bcnt = BUSY;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) rise_cyc = cyc;
        end
        if (req_ack != '0 && !u_tx_data_valid)
          check("ack_without_issue", 32'(u_tx_data_valid), 1);
        if (trunc) trunc_cnt++;
        for (int i = 0; i < NR; i++)
          if (req_ack[i] && rhead[i] != rtail[i]) rhead[i]++;
      end
      u_tx_data_ready = !bp && bcnt == 0;
      for (int i = 0; i < NR; i++) begin
        if (rhead[i] != rtail[i]) begin
          w = rmem[i][rhead[i] % 64];
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = w[7:0];
          req_last[i] = w[8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int c0, i0, t0, n;
    for (int i = 0; i < NR; i++) rtail[i] = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("post_reset");

    // Single 3-byte packet from req0, plus idle-to-issue latency.
    c0 = cyc;
    i0 = issue_cnt;
    drive(0, 8'h41, 0);
    drive(0, 8'h42, 0);
    drive(0, 8'h43, 1);
    expect_b(0, 8'h41);
    expect_b(0, 8'h42);
    expect_b(0, 8'h43);
    wait_issues(i0 + 1, "single_first");
    check("first_issue_latency", cyc - c0, 4);
    wait_idle("single_idle");
    check("single_count", issue_cnt - i0, 3);
    check("single_trunc", trunc_cnt, 0);

    // Fairness from reset: req0, req2, then req3 before req0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i0 = issue_cnt;
    drive(0, 8'h10, 0);
    drive(0, 8'h11, 1);
    drive(2, 8'h20, 0);
    drive(2, 8'h21, 1);
    expect_b(0, 8'h10);
    expect_b(0, 8'h11);
    expect_b(2, 8'h20);
    expect_b(2, 8'h21);
    wait_issues(i0 + 3, "fair_mid");
    check("fair_mid_gid", 32'(grant_id), 2);
    drive(3, 8'h30, 0);
    drive(3, 8'h31, 1);
    drive(0, 8'h12, 1);
    expect_b(3, 8'h30);
    expect_b(3, 8'h31);
    expect_b(0, 8'h12);
    wait_idle("fair_idle");

    // Truncation at MAX_PKT=4, req3 slots in between.
    t0 = trunc_cnt;
    for (int b = 0; b < 6; b++) drive(1, 8'(8'h50 + b), 0);
    drive(3, 8'h60, 0);
    drive(3, 8'h61, 1);
    for (int b = 0; b < 4; b++) expect_b(1, 8'(8'h50 + b));
    expect_b(3, 8'h60);
    expect_b(3, 8'h61);
    expect_b(1, 8'h54);
    expect_b(1, 8'h55);
    wait_idle("trunc_idle");
    check("trunc_pulses", trunc_cnt - t0, 1);

    // Gap timeout: req2 stalls after one byte, req3 follows.
    t0 = trunc_cnt;
    i0 = issue_cnt;
    drive(2, 8'h70, 0);
    drive(3, 8'h80, 1);
    expect_b(2, 8'h70);
    expect_b(3, 8'h80);
    wait_issues(i0 + 1, "gap_first");
    n = 0;
    while (grant_valid && n < 200) begin
      tick();
      n++;
    end
    check("gap_release_seen", 32'(n < 200), 1);
    check("gap_release_time", cyc - rise_cyc, GT + 1);
    wait_idle("gap_idle");
    check("gap_no_trunc", trunc_cnt - t0, 0);

    // Back-pressure: core held not-ready for 500 cycles.
    bp = 1'b1;
    tick();
    tick();
    i0 = issue_cnt;
    drive(0, 8'h90, 1);
    expect_b(0, 8'h90);
    repeat (500) tick();
    check("bp_no_issue", issue_cnt - i0, 0);
    check("bp_no_ack", pend(), 1);
    check("bp_gv", 32'(grant_valid), 1);
    check("bp_gid", 32'(grant_id), 0);
    check("bp_busy", 32'(busy), 1);
    bp = 1'b0;
    wait_idle("bp_idle");
    check("bp_one_issue", issue_cnt - i0, 1);

    // Reset while a byte is draining.
    i0 = issue_cnt;
    drive(1, 8'hA1, 0);
    drive(1, 8'hA2, 0);
    drive(1, 8'hA3, 1);
    expect_b(1, 8'hA1);
    expect_b(1, 8'hA2);
    expect_b(1, 8'hA3);
    wait_issues(i0 + 1, "drain_first");
    tick();
    check("drain_gv", 32'(grant_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_drain");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 8'hB0, 0);
    drive(0, 8'hB1, 1);
    drive(1, 8'hC0, 0);
    drive(1, 8'hC1, 1);
    expect_b(0, 8'hB0);
    expect_b(0, 8'hB1);
    expect_b(1, 8'hC0);
    expect_b(1, 8'hC1);
    wait_idle("after_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
